// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with write-through bypass and an in-flight write scoreboard
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD = 2,
  parameter int MAX_OUT = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  input  logic [NRD-1:0]        rd_use,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic                  stall,
  input  logic                  iss_valid,
  input  logic                  iss_wr_en,
  input  logic [ADDR_W-1:0]     iss_wr_addr,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  flush,
  output logic                  sb_overflow
);
  localparam int NREG = 2**ADDR_W;
  localparam int CW = $clog2(MAX_OUT+1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
  logic [DATA_W-1:0] regs [NREG];
  logic [CW-1:0] cnt [NREG];
  logic [ADDR_W-1:0] ra [NRD];
  logic [NRD-1:0] zr, hit;
  logic [NREG-1:0] inc, dec;
  logic iss_fire, wb_ret, ovf;
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
      zr[i] = ZERO_REG && ra[i] == '0;
      hit[i] = wb_en && wb_addr == ra[i];
      rd_busy[i] = !zr[i] && cnt[ra[i]] != '0 && !hit[i];
    end
  end
  assign stall = |(rd_busy & rd_use);
  assign iss_fire = iss_valid && !stall && !flush && iss_wr_en && !(ZERO_REG && iss_wr_addr == '0);
  assign wb_ret = wb_en && !(ZERO_REG && wb_addr == '0);
  // an issue and a retire to the same register cancel, so only an unmatched issue can overflow
  assign ovf = iss_fire && !(wb_ret && wb_addr == iss_wr_addr) && cnt[iss_wr_addr] == MAX_C;
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc[r] = iss_fire && iss_wr_addr == ADDR_W'(r);
      dec[r] = wb_ret && wb_addr == ADDR_W'(r);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_overflow <= 1'b0;
    end else begin
      sb_overflow <= sb_overflow | ovf;
      for (int r = 0; r < NREG; r++) begin
        if (flush) cnt[r] <= '0;
        else if (inc[r] && !dec[r] && cnt[r] != MAX_C) cnt[r] <= cnt[r] + 1'b1;
        else if (dec[r] && !inc[r] && cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wb_ret) begin
      regs[wb_addr] <= wb_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      for (int i = 0; i < NRD; i++)
        rd_data[i*DATA_W +: DATA_W] <= zr[i] ? '0 : hit[i] ? wb_data : regs[ra[i]];
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed plus random checks of regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] rd_addr;
  logic [1:0] rd_use, rd_busy;
  logic [63:0] rd_data;
  logic stall, iss_valid, iss_wr_en, wb_en, flush, sb_overflow;
  logic [4:0] iss_wr_addr, wb_addr;
  logic [31:0] wb_data;
  int ncmp = 0, nerr = 0;
  int m_cnt [32];
  logic [31:0] m_reg [32];
  logic [63:0] m_rd;
  logic m_ovf;
  always #5 clk = ~clk;
  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
    .rd_busy(rd_busy), .stall(stall), .iss_valid(iss_valid), .iss_wr_en(iss_wr_en),
    .iss_wr_addr(iss_wr_addr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .sb_overflow(sb_overflow)
  );
  task automatic idle();
    rd_addr = '0; rd_use = '0; iss_valid = 0; iss_wr_en = 0; iss_wr_addr = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
  endtask
  task automatic m_reset();
    foreach (m_cnt[r]) begin m_cnt[r] = 0; m_reg[r] = '0; end
    m_rd = '0; m_ovf = 0;
  endtask
  function automatic logic [1:0] m_busy();
    logic [1:0] b;
    logic [4:0] a;
    for (int i = 0; i < 2; i++) begin
      a = rd_addr[i*5 +: 5];
      b[i] = a != 0 && m_cnt[a] != 0 && !(wb_en && wb_addr == a);
    end
    return b;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic settle();
    #1;
    chk("rd_busy", {62'd0, rd_busy}, {62'd0, m_busy()});
    chk("stall", {63'd0, stall}, {63'd0, |(m_busy() & rd_use)});
  endtask
  task automatic tick();
    logic st, fire, ret;
    logic [4:0] a;
    st = |(m_busy() & rd_use);
    for (int i = 0; i < 2; i++) begin
      a = rd_addr[i*5 +: 5];
      m_rd[i*32 +: 32] = a == 0 ? 32'd0 : (wb_en && wb_addr == a) ? wb_data : m_reg[a];
    end
    fire = iss_valid && iss_wr_en && !st && !flush && iss_wr_addr != 0;
    ret = wb_en && wb_addr != 0;
    if (flush) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
    end else if (!(fire && ret && iss_wr_addr == wb_addr)) begin
      if (fire) begin
        if (m_cnt[iss_wr_addr] < 3) m_cnt[iss_wr_addr]++;
        else m_ovf = 1;
      end
      if (ret && m_cnt[wb_addr] > 0) m_cnt[wb_addr]--;
    end
    if (ret) m_reg[wb_addr] = wb_data;
    @(posedge clk);
    @(negedge clk);
    chk("rd_data", rd_data, m_rd);
    chk("sb_overflow", {63'd0, sb_overflow}, {63'd0, m_ovf});
  endtask
  initial begin
    idle();
    m_reset();
    #2;
    chk("rst_data", rd_data, 64'd0);
    chk("rst_busy", {62'd0, rd_busy}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_ovf", {63'd0, sb_overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    // basic write then read
    wb_en = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF;
    settle(); tick();
    idle(); rd_addr[4:0] = 5;
    settle();
    chk("t1_busy", {63'd0, rd_busy[0]}, 64'd0);
    tick();
    chk("t1_data", {32'd0, rd_data[31:0]}, {32'd0, 32'hDEAD_BEEF});
    // bypass and zero register
    idle(); wb_en = 1; wb_addr = 7; wb_data = 32'h1234; rd_addr[9:5] = 7;
    settle(); tick();
    chk("bypass", {32'd0, rd_data[63:32]}, 64'h1234);
    idle(); wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    settle(); tick();
    chk("zero_reg", {32'd0, rd_data[31:0]}, 64'd0);
    // RAW stall, with a re-presented instruction held off
    idle(); iss_valid = 1; iss_wr_en = 1; iss_wr_addr = 3;
    settle(); tick();
    idle(); rd_addr[4:0] = 3; rd_use = 2'b01; iss_valid = 1; iss_wr_en = 1; iss_wr_addr = 10;
    settle();
    chk("raw_stall", {63'd0, stall}, 64'd1);
    chk("raw_busy", {62'd0, rd_busy}, 64'd1);
    tick(); settle(); tick();
    wb_en = 1; wb_addr = 3; wb_data = 32'h5555_AAAA;
    settle();
    chk("raw_release", {63'd0, stall}, 64'd0);
    tick();
    chk("raw_data", {32'd0, rd_data[31:0]}, 64'h5555_AAAA);
    // WAW saturation on r9
    idle(); iss_valid = 1; iss_wr_en = 1; iss_wr_addr = 9;
    for (int k = 0; k < 4; k++) begin settle(); tick(); end
    chk("sat_ovf", {63'd0, sb_overflow}, 64'd1);
    idle(); rd_addr[9:5] = 9; wb_en = 1; wb_addr = 9;
    for (int k = 0; k < 2; k++) begin wb_data = 32'h900 + k; settle(); tick(); end
    wb_en = 0;
    settle();
    chk("waw_busy", {63'd0, rd_busy[1]}, 64'd1);
    wb_en = 1; wb_data = 32'h902;
    settle(); tick();
    wb_en = 0;
    settle();
    chk("waw_clear", {63'd0, rd_busy[1]}, 64'd0);
    chk("ovf_sticky", {63'd0, sb_overflow}, 64'd1);
    // flush squashes pending writes and the concurrent issue
    idle(); iss_valid = 1; iss_wr_en = 1; iss_wr_addr = 4;
    settle(); tick();
    iss_wr_addr = 6;
    settle(); tick();
    iss_wr_addr = 8; flush = 1;
    settle(); tick();
    idle(); rd_addr = {5'd6, 5'd4};
    settle();
    chk("flush_busy", {62'd0, rd_busy}, 64'd0);
    rd_addr = {5'd8, 5'd8};
    settle();
    chk("flush_r8", {62'd0, rd_busy}, 64'd0);
    idle(); wb_en = 1; wb_addr = 4; wb_data = 32'hCAFE_0004;
    settle(); tick();
    idle(); rd_addr[4:0] = 4;
    settle(); tick();
    chk("stale_wb", {32'd0, rd_data[31:0]}, 64'hCAFE_0004);
    // simultaneous issue and write-back to r2
    idle(); iss_valid = 1; iss_wr_en = 1; iss_wr_addr = 2;
    settle(); tick();
    wb_en = 1; wb_addr = 2; wb_data = 32'h22;
    settle(); tick();
    idle(); rd_addr[4:0] = 2; rd_use = 2'b01;
    settle();
    chk("sim_busy", {63'd0, rd_busy[0]}, 64'd1);
    // asynchronous reset pulse mid-sequence
    #1 rst_n = 0;
    #1;
    m_reset();
    chk("areset_data", rd_data, 64'd0);
    chk("areset_stall", {63'd0, stall}, 64'd0);
    chk("areset_busy", {62'd0, rd_busy}, 64'd0);
    chk("areset_ovf", {63'd0, sb_overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rd_use = 2'($urandom);
      iss_valid = 1'($urandom_range(0, 1));
      iss_wr_en = $urandom_range(0, 3) != 0;
      iss_wr_addr = 5'($urandom_range(0, 7));
      wb_en = $urandom_range(0, 2) == 0;
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      flush = $urandom_range(0, 40) == 0;
      settle(); tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
